// File: rtl/iir_pkg.sv
// Shared types and constants for the sequential biquad IIR stage.
package iir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam int DW_DEF   = 16;
  localparam int CW_DEF   = 16;
  localparam int FRAC_DEF = 14;

  // Three guard bits cover the sum of five full-scale products.
  function automatic int acc_width(input int dw, input int cw);
    return dw + cw + 3;
  endfunction

  // Half an LSB of the output, preloaded so the final shift rounds half-up.
  function automatic int round_const(input int frac);
    return 1 << (frac - 1);
  endfunction

endpackage

// File: rtl/iir_biquad_mac.sv
// Registered signed multiply-accumulate; one biquad term per enabled cycle, selected by idx.
module iir_biquad_mac
  import iir_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int CW    = CW_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int ACC_W = acc_width(DW, CW)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic [2:0]              idx_i,
  input  logic signed [DW-1:0]    x0_i,
  input  logic signed [DW-1:0]    x1_i,
  input  logic signed [DW-1:0]    x2_i,
  input  logic signed [DW-1:0]    y1_i,
  input  logic signed [DW-1:0]    y2_i,
  input  logic signed [CW-1:0]    b0_i,
  input  logic signed [CW-1:0]    b1_i,
  input  logic signed [CW-1:0]    b2_i,
  input  logic signed [CW-1:0]    a1_i,
  input  logic signed [CW-1:0]    a2_i,
  output logic signed [ACC_W-1:0] acc_o
);

  localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(round_const(FRAC));

  logic signed [DW-1:0]    op;
  logic signed [CW-1:0]    coef;
  logic                    sub;
  logic signed [DW+CW-1:0] prod;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    op   = '0;
    coef = '0;
    sub  = 1'b0;
    case (idx_i)
      3'd0: begin op = x0_i; coef = b0_i; end
      3'd1: begin op = x1_i; coef = b1_i; end
      3'd2: begin op = x2_i; coef = b2_i; end
      3'd3: begin op = y1_i; coef = a1_i; sub = 1'b1; end
      3'd4: begin op = y2_i; coef = a2_i; sub = 1'b1; end
      default: ;
    endcase
    prod  = (DW+CW)'(op) * (DW+CW)'(coef);
    acc_d = sub ? (acc_q - ACC_W'(prod)) : (acc_q + ACC_W'(prod));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= ROUND;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/iir_biquad_seq.sv
// Time-shared biquad IIR: one filtered sample per clk_40k rising edge, 5 MAC cycles each.
// Define IIR_SAT_EN to clamp the result to the DW range instead of two's-complement wrap.
module iir_biquad_seq
  import iir_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int CW   = CW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_40k,
  input  logic signed [DW-1:0] din,
  input  logic signed [CW-1:0] b0,
  input  logic signed [CW-1:0] b1,
  input  logic signed [CW-1:0] b2,
  input  logic signed [CW-1:0] a1,
  input  logic signed [CW-1:0] a2,
  output logic signed [DW-1:0] dout,
  output logic                 dout_valid,
  output logic                 busy
);

  localparam int ACC_W = acc_width(DW, CW);

  state_e               state_q;
  logic                 clk_40k_q;
  logic [2:0]           idx_q;
  logic signed [DW-1:0] x0_q, x1_q, x2_q, y1_q, y2_q;
  logic signed [CW-1:0] b0_q, b1_q, b2_q, a1_q, a2_q;
  logic signed [DW-1:0] dout_q;
  logic                 dout_valid_q;
  logic                 busy_q;

  logic                    start;
  logic signed [ACC_W-1:0] acc;
  logic signed [DW-1:0]    result_d;

  // Edges arriving outside IDLE are dropped, never queued.
  assign start = clk_40k && !clk_40k_q && (state_q == IDLE);

  iir_biquad_mac #(
    .DW   (DW),
    .CW   (CW),
    .FRAC (FRAC),
    .ACC_W(ACC_W)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr_i(start),
    .en_i (state_q == MAC),
    .idx_i(idx_q),
    .x0_i (x0_q),
    .x1_i (x1_q),
    .x2_i (x2_q),
    .y1_i (y1_q),
    .y2_i (y2_q),
    .b0_i (b0_q),
    .b1_i (b1_q),
    .b2_i (b2_q),
    .a1_i (a1_q),
    .a2_i (a2_q),
    .acc_o(acc)
  );

`ifdef IIR_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = acc >>> FRAC;
    if (shifted > MAX_V) begin
      result_d = MAX_V[DW-1:0];
    end else if (shifted < MIN_V) begin
      result_d = MIN_V[DW-1:0];
    end else begin
      result_d = shifted[DW-1:0];
    end
  end
`else
  always_comb begin
    result_d = DW'(acc >>> FRAC);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      clk_40k_q    <= 1'b0;
      idx_q        <= '0;
      x0_q         <= '0;
      x1_q         <= '0;
      x2_q         <= '0;
      y1_q         <= '0;
      y2_q         <= '0;
      b0_q         <= '0;
      b1_q         <= '0;
      b2_q         <= '0;
      a1_q         <= '0;
      a2_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      clk_40k_q    <= clk_40k;
      dout_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            x0_q    <= din;
            b0_q    <= b0;
            b1_q    <= b1;
            b2_q    <= b2;
            a1_q    <= a1;
            a2_q    <= a2;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= MAC;
          end
        end
        MAC: begin
          idx_q <= idx_q + 3'd1;
          if (idx_q == 3'd4) begin
            state_q <= OUT;
          end
        end
        OUT: begin
          // History stores the post-clamp/wrap value so feedback matches dout.
          dout_q       <= result_d;
          dout_valid_q <= 1'b1;
          x2_q         <= x1_q;
          x1_q         <= x0_q;
          y2_q         <= y1_q;
          y1_q         <= result_d;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_iir_biquad_seq.sv
// Scoreboard bench for iir_biquad_seq: reference model pushes expected outputs at each accepted strobe.
module tb_iir_biquad_seq;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               clk_40k = 1'b0;
  logic signed [15:0] din = '0;
  logic signed [15:0] b0 = '0, b1 = '0, b2 = '0, a1 = '0, a2 = '0;
  logic signed [15:0] dout;
  logic               dout_valid;
  logic               busy;

  int n_cmp = 0;
  int n_err = 0;
  int valid_cnt = 0;

  logic signed [15:0] exp_q[$];
  logic signed [15:0] mx1 = '0, mx2 = '0, my1 = '0, my2 = '0;

  iir_biquad_seq dut (
    .clk       (clk),
    .rst       (rst),
    .clk_40k   (clk_40k),
    .din       (din),
    .b0        (b0),
    .b1        (b1),
    .b2        (b2),
    .a1        (a1),
    .a2        (a2),
    .dout      (dout),
    .dout_valid(dout_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic signed [63:0] obs,
                           input logic signed [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic signed [15:0] model_y(input logic signed [15:0] x);
    longint acc;
    longint sh;
    acc = 64'sd8192 + longint'(b0) * longint'(x) + longint'(b1) * longint'(mx1)
        + longint'(b2) * longint'(mx2) - longint'(a1) * longint'(my1)
        - longint'(a2) * longint'(my2);
    sh = acc >>> 14;
`ifdef IIR_SAT_EN
    if (sh > 32767) sh = 32767;
    if (sh < -32768) sh = -32768;
`endif
    return sh[15:0];
  endfunction

  task automatic push_model(input logic signed [15:0] x);
    logic signed [15:0] y;
    y = model_y(x);
    exp_q.push_back(y);
    mx2 = mx1;
    mx1 = x;
    my2 = my1;
    my1 = y;
  endtask

  task automatic clear_model();
    exp_q.delete();
    mx1 = '0; mx2 = '0; my1 = '0; my2 = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    clk_40k = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // One strobe pulse, then enough idle cycles for the result to emerge.
  task automatic send(input logic signed [15:0] x);
    @(posedge clk);
    #1 din = x;
    clk_40k = 1'b1;
    push_model(x);
    @(posedge clk);
    #1 clk_40k = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  always @(negedge clk) begin : monitor
    logic signed [15:0] e;
    if (rst && dout_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        $display("txn: dout=%0d expected=%0d", dout, e);
        check_val("dout", dout, e);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int accepted;
    int last;

    // Reset state
    @(negedge clk);
    check_val("rst_dout", dout, 0);
    check_val("rst_valid", dout_valid, 0);
    check_val("rst_busy", busy, 0);

    // Identity with latency / busy window
    do_reset();
    b0 = 16'sd16384;
    @(posedge clk);
    #1 din = 16'sd1000;
    clk_40k = 1'b1;
    push_model(16'sd1000);
    @(posedge clk);
    #1 clk_40k = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      check_val($sformatf("busy_e%0d", k), busy, (k <= 5) ? 1 : 0);
      check_val($sformatf("valid_e%0d", k), dout_valid, (k == 6) ? 1 : 0);
    end
    check_val("id_dout", dout, 1000);
    repeat (5) @(posedge clk);

    // Pure delay
    do_reset();
    b0 = '0; b2 = 16'sd16384;
    send(16'sd1000);
    send(16'sd0);
    send(16'sd0);
    check_val("delay_dout2", dout, 1000);
    send(16'sd0);
    check_val("delay_dout3", dout, 0);

    // Feedback step
    do_reset();
    b0 = 16'sd16384; b2 = '0; a1 = -16'sd8192;
    for (int i = 0; i < 4; i++) send(16'sd1000);
    check_val("fb_dout3", dout, 1875);

    // Overflow
    do_reset();
    a1 = '0; b0 = 16'sd32767;
    send(16'sd30000);
`ifdef IIR_SAT_EN
    check_val("ovf_dout", dout, 32767);
`else
    check_val("ovf_dout", dout, -5538);
`endif

    // Reset in the middle of the MAC phase
    do_reset();
    b0 = 16'sd16384;
    @(posedge clk);
    #1 din = 16'sd1000;
    clk_40k = 1'b1;
    @(posedge clk);
    #1 clk_40k = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("mid_rst_dout", dout, 0);
    check_val("mid_rst_valid", dout_valid, 0);
    check_val("mid_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    clear_model();
    repeat (10) @(posedge clk);
    send(16'sd500);
    check_val("post_rst_dout", dout, 500);

    // Strobe edges every 3 cycles; coefficient changes while busy
    do_reset();
    b0 = 16'sd16384; b1 = 16'sd8192;
    valid_cnt = 0;
    accepted = 0;
    last = -100;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1 din = 16'(int'($urandom_range(0, 4000)) - 2000);
      clk_40k = 1'b1;
      if (i * 3 - last >= 7) begin
        push_model(din);
        last = i * 3;
        accepted++;
      end
      @(posedge clk);
      #1 clk_40k = 1'b0;
      b0 = 16'($urandom_range(4096, 16384));
      @(posedge clk);
    end
    repeat (20) @(posedge clk);
    check_val("valid_count", valid_cnt, accepted);
    check_val("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
